// File: rtl/sum_pkg.sv
// Shared types for the summer result queue.
// One queue entry is a sum plus an error-record flag.
package sum_pkg;

    localparam int SUM_W = 16;

    typedef struct packed {
        logic             err;
        logic [SUM_W-1:0] sum;
    } result_t;

endpackage

// File: rtl/res_fifo.sv
// Result storage: circular buffer with separate occupancy counter.
// A push while full is taken only when a pop frees the slot that cycle.
module res_fifo
    import sum_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  result_t wdata,
    output result_t rdata,
    output logic    empty,
    output logic    full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    result_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sum_result_queue.sv
// Queues completed sums and error records from the upstream summer,
// keeping saturating per-type counts and a sticky overflow flag.
module sum_result_queue
    import sum_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             done,
    input  logic             err,
    input  logic [SUM_W-1:0] sum,
    input  logic             clr_stat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic             out_err,
    output logic             full,
    output logic             drop,
    output logic [CNTW-1:0]  res_cnt,
    output logic [CNTW-1:0]  err_cnt
);

    logic    err_q;
    logic    good_req;
    logic    err_req;
    logic    push_req;
    logic    pop;
    logic    accept;
    logic    empty;
    result_t wdata;
    result_t rdata;

    // done is active-low; an error edge outranks a done pulse.
    assign good_req = !done && !err;
    assign err_req  = err && !err_q;
    assign push_req = good_req || err_req;
    assign pop      = out_valid && out_ready;
    assign accept   = push_req && (!full || pop);

    always_comb begin
        wdata = '0;
        if (err_req)
            wdata.err = 1'b1;
        else
            wdata.sum = sum;
    end

    res_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (accept),
        .pop  (pop),
        .wdata(wdata),
        .rdata(rdata),
        .empty(empty),
        .full (full)
    );

    assign out_valid = !empty;
    assign out_sum   = rdata.sum;
    assign out_err   = rdata.err;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q   <= 1'b0;
            drop    <= 1'b0;
            res_cnt <= '0;
            err_cnt <= '0;
        end else begin
            err_q <= err;
            if (clr_stat) begin
                drop    <= 1'b0;
                res_cnt <= '0;
                err_cnt <= '0;
            end else begin
                if (push_req && !accept)
                    drop <= 1'b1;
                if (accept && good_req && res_cnt != '1)
                    res_cnt <= res_cnt + 1'b1;
                if (accept && err_req && err_cnt != '1)
                    err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sum_result_queue.sv
// Scoreboard bench: reference queue model fed by stimulus, checked by a
// monitor at each handshake; a CNTW=2 twin covers counter saturation.
module tb_sum_result_queue;
    import sum_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        done = 1'b1;
    logic        err = 1'b0;
    logic [15:0] sum = '0;
    logic        clr_stat = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid, out_err, full, drop;
    logic [15:0] out_sum;
    logic [7:0]  res_cnt, err_cnt;
    logic        out_valid2, out_err2, full2, drop2;
    logic [15:0] out_sum2;
    logic [1:0]  res_cnt2, err_cnt2;

    int n_chk = 0;
    int n_fail = 0;

    result_t sb[$];
    int  m_res = 0, m_err = 0, m_res2 = 0, m_err2 = 0;
    bit  m_drop = 0, m_errq = 0;

    always #5 clk = ~clk;

    sum_result_queue #(.DEPTH(4), .CNTW(8)) dut (
        .clk(clk), .rst(rst), .done(done), .err(err), .sum(sum),
        .clr_stat(clr_stat), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_err(out_err), .full(full), .drop(drop),
        .res_cnt(res_cnt), .err_cnt(err_cnt)
    );

    sum_result_queue #(.DEPTH(4), .CNTW(2)) dut2 (
        .clk(clk), .rst(rst), .done(done), .err(err), .sum(sum),
        .clr_stat(clr_stat), .out_valid(out_valid2), .out_ready(out_ready),
        .out_sum(out_sum2), .out_err(out_err2), .full(full2), .drop(drop2),
        .res_cnt(res_cnt2), .err_cnt(err_cnt2)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: just before each rising edge, compare any accepted head.
    initial begin
        result_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pop", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_sum", int'(out_sum), int'(e.sum));
                    chk("out_err", int'(out_err), int'(e.err));
                    chk("twin_sum", int'(out_sum2), int'(e.sum));
                end
            end
        end
    end

    function automatic int sat(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    // One cycle: check state from the last edge, drive inputs, advance model.
    task automatic cyc(input bit d, input bit e, input logic [15:0] s,
                       input bit rdy, input bit clr, input bit r);
        bit good, erp, pop, fl;
        result_t ent;
        @(negedge clk);
        chk("out_valid", int'(out_valid), int'(sb.size() != 0));
        chk("full", int'(full), int'(sb.size() == 4));
        chk("drop", int'(drop), int'(m_drop));
        chk("res_cnt", int'(res_cnt), m_res);
        chk("err_cnt", int'(err_cnt), m_err);
        chk("res_cnt_sat", int'(res_cnt2), m_res2);
        chk("err_cnt_sat", int'(err_cnt2), m_err2);
        done = d; err = e; sum = s;
        out_ready = rdy; clr_stat = clr; rst = r;
        if (r) begin
            sb.delete();
            m_res = 0; m_err = 0; m_res2 = 0; m_err2 = 0;
            m_drop = 0; m_errq = 0;
        end else begin
            good = !d && !e;
            erp  = e && !m_errq;
            pop  = rdy && sb.size() != 0;
            fl   = sb.size() == 4;
            if (good || erp) begin
                if (!fl || pop) begin
                    ent.err = erp;
                    ent.sum = erp ? 16'h0000 : s;
                    sb.push_back(ent);
                    if (!clr) begin
                        if (good) begin
                            m_res = sat(m_res, 255);
                            m_res2 = sat(m_res2, 3);
                        end else begin
                            m_err = sat(m_err, 255);
                            m_err2 = sat(m_err2, 3);
                        end
                    end
                end else begin
                    m_drop = 1;
                end
            end
            if (clr) begin
                m_res = 0; m_err = 0; m_res2 = 0; m_err2 = 0; m_drop = 0;
            end
            m_errq = e;
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1, 0, 16'h0, rdy, 0, 0);
    endtask

    initial begin
        bit pd, pe;
        int k;
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        idle(1, 1);
        // two good results
        cyc(0, 0, 16'h1234, 1, 0, 0);
        cyc(1, 0, 16'h0, 1, 0, 0);
        cyc(0, 0, 16'h0042, 1, 0, 0);
        idle(3, 1);
        // error level for five cycles with a done pulse inside
        for (int i = 0; i < 5; i++)
            cyc(i == 2 ? 1'b0 : 1'b1, 1, 16'hbeef, 1, 0, 0);
        idle(3, 1);
        // overflow with consumer stalled
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 0, 16'(i), 0, 0, 0);
            cyc(1, 0, 16'h0, 0, 0, 0);
        end
        cyc(1, 0, 16'h0, 0, 1, 0);
        // full, concurrent push and pop
        cyc(0, 0, 16'h00aa, 1, 0, 0);
        idle(6, 1);
        // reset with entries held, then clear alongside a push
        for (int i = 0; i < 3; i++) cyc(0, 0, 16'(16'h10 + i), 0, 0, 0);
        cyc(1, 0, 16'h0, 0, 0, 1);
        idle(1, 0);
        cyc(0, 0, 16'h0077, 0, 1, 0);
        idle(3, 1);
        // saturation of the 2-bit twin
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 16'(16'h100 + i), 1, 0, 0);
            cyc(1, 0, 16'h0, 1, 0, 0);
        end
        idle(2, 1);
        // random traffic
        pd = 1; pe = 0;
        for (int i = 0; i < 400; i++) begin
            bit d, e;
            d = (pd == 0) ? 1'b1 : ($urandom_range(3) != 0);
            e = ($urandom_range(7) == 0) ? ~pe : pe;
            cyc(d, e, 16'($urandom), $urandom_range(1) == 1,
                $urandom_range(49) == 0, $urandom_range(99) == 0);
            pd = d; pe = e;
        end
        // bounded drain
        k = 0;
        while (sb.size() != 0 && k < 20) begin
            idle(1, 1);
            k++;
        end
        idle(1, 1);
        chk("drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
